pi_request_queue: RTL and testbench
===================================

# pi_request_queue

Request queue between the Pi register interface and the Amiga bus state machine in the PiStorm16 gateware. It collects Pi register writes into a staged request and commits the request on the ADDR_HI write. Committed requests are held in a small FIFO and presented one at a time to the bus FSM through a valid/take/done handshake. Writes are posted, so the Pi keeps going while the bus drains. Reads, a full queue, or posting disabled hold BUSY, which drives the Pi-visible GPIO3 status.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16
- LW, $clog2(DEPTH+1), width of LEVEL

Ports:
- SYSCLK  in  1  system clock (PLL output); all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- PI_WR_STROBE  in  1  one-SYSCLK pulse per Pi write, already synchronized and edge-detected
- PI_A  in  3  Pi register address, decoded with PI_REG_* codes from global.vh
- PI_DATA  in  16  Pi write data, valid with PI_WR_STROBE
- CMD_VALID  out  1  head entry available to bus FSM
- CMD_ADDR  out  24  head address
- CMD_FC  out  3  head function code
- CMD_READ  out  1  head is a read
- CMD_SIZE  out  2  head size field: bit0 = 16-bit, bit1 = 32-bit (two words)
- CMD_DATA  out  32  head write data
- CMD_TAKE  in  1  pulse: FSM accepts head (pop)
- CMD_DONE  in  1  pulse: accepted bus cycle fully finished
- BUSY  out  1  Pi must wait before the next commit or a data readback
- FULL  out  1  LEVEL == DEPTH
- LEVEL  out  LW  queued entries, excluding the outstanding entry
- OVERFLOW  out  1  sticky: a commit was dropped because the queue was full

## Operation
- Staging registers: DATA_LO→stg_data[15:0], DATA_HI→stg_data[31:16], ADDR_LO→stg_addr[15:0].
- Staging registers are loaded on PI_WR_STROBE and keep their values across commits.
- Commit on PI_WR_STROBE with PI_A == PI_REG_ADDR_HI. The entry written is:
  - addr = {PI_DATA[7:0], stg_addr[15:0]}
  - size = PI_DATA[9:8]
  - read = PI_DATA[10]
  - fc = PI_DATA[13:11]
  - data = stg_data
- Other PI_A values (STATUS, VERSION, CONTROL) are ignored.
- Commit while FULL and no same-cycle pop: the entry is dropped, OVERFLOW is set, and the FIFO is unchanged.
- Issue state machine:
  - IDLE: CMD_VALID = (LEVEL != 0). CMD_TAKE while CMD_VALID pops the head, latches it into the outstanding register, and moves to ISSUED.
  - ISSUED: CMD_VALID = 0. CMD_DONE returns to IDLE.
  - CMD_TAKE while CMD_VALID = 0 is ignored. CMD_DONE in IDLE is ignored.
- CMD_* outputs show the FIFO head in IDLE and the outstanding register in ISSUED. They hold stable from TAKE until DONE.
- BUSY = FULL | read_pending | (!posted & (LEVEL != 0 | ISSUED)).
  - read_pending is 1 while any queued or outstanding entry has read = 1.
  - read_pending is held with a per-entry read counter, 0..DEPTH+1, incremented on a read commit and decremented on DONE of a read.
- Pointers: LW-1-bit read/write indices wrapping modulo DEPTH. LEVEL is tracked separately: +1 on commit, −1 on pop, unchanged on both.

## Timing
- Reset values:
  - CMD_VALID, BUSY, FULL, OVERFLOW, LEVEL = 0
  - state = IDLE
  - staging registers, CMD_* = 0
  - read counter and pointers = 0
- Commit at cycle N: LEVEL, FULL and BUSY update at N+1. CMD_VALID rises at N+1 if the queue was empty and in IDLE.
- TAKE at cycle N: state = ISSUED and CMD_VALID = 0 at N+1. LEVEL decrements at N+1.
- DONE at cycle N: IDLE at N+1. The next head's CMD_VALID can be 1 at N+1, giving a one-cycle bubble-free turnaround.
- Commit and TAKE in the same cycle: both are performed and LEVEL is unchanged. When FULL, the commit is accepted because a slot frees the same cycle.
- Commit and DONE in the same cycle: both are performed. The read counter applies +1 and −1 net.
- RESET mid-cycle (ISSUED): the outstanding entry is abandoned and all state is cleared next cycle. Bus-side recovery belongs to the FSM.

## Configuration
- PS16_POSTED_WRITE_EN:
  - Defined: writes are posted and BUSY follows the full formula above.
  - Undefined: `posted` is constant 0, so BUSY is high whenever any entry is queued or outstanding. This matches the non-buffered single-request behaviour.
  - Undefined: DEPTH is still honoured, but the Pi protocol never exceeds one entry.

## Test plan
- Posted writes: stage DATA=0xDEADBEEF, ADDR_LO=0x1234, commit ADDR_HI=0x0BE5 (fc 1, write, size 0b11, addr 0xE51234).
  - Required: CMD_VALID next cycle, CMD_ADDR=0xE51234, CMD_FC=1, CMD_SIZE=3, CMD_DATA=0xDEADBEEF, BUSY=0 with the macro defined.
- Fill/overflow, DEPTH=4, no TAKE, 5 commits.
  - Required: LEVEL=4, FULL=1, BUSY=1, OVERFLOW=1. Entries 1–4 pop in order with CMD_ADDR unchanged by the dropped fifth.
- Read blocking: 2 posted writes, then a read commit.
  - Required: BUSY=1 until DONE of the third entry. BUSY=0 the cycle after that DONE.
- Simultaneous commit+TAKE when FULL: LEVEL stays 4, OVERFLOW stays 0, FIFO order preserved.
- Stray handshakes: DONE in IDLE and TAKE with an empty queue produce no state change and LEVEL=0. RESET asserted in ISSUED gives CMD_VALID=0, LEVEL=0, OVERFLOW=0 next cycle.
- Macro undefined: a single write commit gives BUSY=1 from the next cycle until the cycle after DONE.

Source files
------------

// File: rtl/pi_request_queue.sv
// Posted-write request queue between the Pi register interface and the Amiga bus FSM.
// Optional feature: define PS16_POSTED_WRITE_EN to let BUSY drop while writes are queued.
module pi_request_queue #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          SYSCLK,
  input  logic          RESET,
  input  logic          PI_WR_STROBE,
  input  logic [2:0]    PI_A,
  input  logic [15:0]   PI_DATA,
  output logic          CMD_VALID,
  output logic [23:0]   CMD_ADDR,
  output logic [2:0]    CMD_FC,
  output logic          CMD_READ,
  output logic [1:0]    CMD_SIZE,
  output logic [31:0]   CMD_DATA,
  input  logic          CMD_TAKE,
  input  logic          CMD_DONE,
  output logic          BUSY,
  output logic          FULL,
  output logic [LW-1:0] LEVEL,
  output logic          OVERFLOW
);

  localparam logic [2:0] PI_REG_DATA_LO = 3'd0;
  localparam logic [2:0] PI_REG_DATA_HI = 3'd1;
  localparam logic [2:0] PI_REG_ADDR_LO = 3'd2;
  localparam logic [2:0] PI_REG_ADDR_HI = 3'd3;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ISSUED = 1'b1;

  localparam int PW = LW - 1;
  localparam int CW = $clog2(DEPTH + 2);
  localparam int EW = 62;

  // Entry layout: {addr[61:38], fc[37:35], read[34], size[33:32], data[31:0]}
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] out_reg;
  logic [EW-1:0] head;
  logic [EW-1:0] new_entry;
  logic [EW-1:0] shown;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] level;
  logic [CW-1:0] rd_cnt;
  logic [31:0]   stg_data;
  logic [15:0]   stg_addr;
  logic          state;
  logic          overflow;
  logic          posted;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          done;
  logic          full;
  logic          valid;
  logic          rd_inc;
  logic          rd_dec;

`ifdef PS16_POSTED_WRITE_EN
  assign posted = 1'b1;
`else
  assign posted = 1'b0;
`endif

  always_comb begin
    head      = mem[rd_ptr];
    new_entry = {PI_DATA[7:0], stg_addr, PI_DATA[13:11], PI_DATA[10], PI_DATA[9:8], stg_data};
    full      = (level == LW'(DEPTH));
    valid     = (state == ST_IDLE) && (level != '0);
    push      = PI_WR_STROBE && (PI_A == PI_REG_ADDR_HI);
    pop       = CMD_TAKE && valid;
    // A full queue still accepts a commit when the head leaves in the same cycle.
    push_ok   = push && (!full || pop);
    done      = CMD_DONE && (state == ST_ISSUED);
    rd_inc    = push_ok && PI_DATA[10];
    rd_dec    = done && out_reg[34];
    shown     = (state == ST_ISSUED) ? out_reg : head;
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      out_reg  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      rd_cnt   <= '0;
      stg_data <= '0;
      stg_addr <= '0;
      state    <= ST_IDLE;
      overflow <= 1'b0;
    end else begin
      if (PI_WR_STROBE) begin
        case (PI_A)
          PI_REG_DATA_LO: stg_data[15:0]  <= PI_DATA;
          PI_REG_DATA_HI: stg_data[31:16] <= PI_DATA;
          PI_REG_ADDR_LO: stg_addr        <= PI_DATA;
          default: ;
        endcase
      end

      if (push_ok) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (push && full && !pop) overflow <= 1'b1;

      if (pop) begin
        out_reg <= head;
        rd_ptr  <= rd_ptr + 1'b1;
        state   <= ST_ISSUED;
      end else if (done) begin
        state <= ST_IDLE;
      end

      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase

      case ({rd_inc, rd_dec})
        2'b10:   rd_cnt <= rd_cnt + 1'b1;
        2'b01:   rd_cnt <= rd_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign CMD_VALID = valid;
  assign CMD_ADDR  = shown[61:38];
  assign CMD_FC    = shown[37:35];
  assign CMD_READ  = shown[34];
  assign CMD_SIZE  = shown[33:32];
  assign CMD_DATA  = shown[31:0];
  assign FULL      = full;
  assign LEVEL     = level;
  assign OVERFLOW  = overflow;
  assign BUSY      = full || (rd_cnt != '0) ||
                     (!posted && ((level != '0) || (state == ST_ISSUED)));

endmodule

// File: tb/tb_pi_request_queue.sv
// Directed self-checking bench for pi_request_queue (DEPTH = 4); expectations adapt to PS16_POSTED_WRITE_EN.
module tb_pi_request_queue;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  localparam logic [2:0] R_DATA_LO = 3'd0;
  localparam logic [2:0] R_DATA_HI = 3'd1;
  localparam logic [2:0] R_ADDR_LO = 3'd2;
  localparam logic [2:0] R_ADDR_HI = 3'd3;
  localparam logic [2:0] R_STATUS  = 3'd4;
  localparam logic [2:0] R_VERSION = 3'd5;
  localparam logic [2:0] R_CONTROL = 3'd6;

`ifdef PS16_POSTED_WRITE_EN
  localparam logic POSTED = 1'b1;
`else
  localparam logic POSTED = 1'b0;
`endif

  logic          SYSCLK = 1'b0;
  logic          RESET = 1'b1;
  logic          PI_WR_STROBE = 1'b0;
  logic [2:0]    PI_A = '0;
  logic [15:0]   PI_DATA = '0;
  logic          CMD_VALID;
  logic [23:0]   CMD_ADDR;
  logic [2:0]    CMD_FC;
  logic          CMD_READ;
  logic [1:0]    CMD_SIZE;
  logic [31:0]   CMD_DATA;
  logic          CMD_TAKE = 1'b0;
  logic          CMD_DONE = 1'b0;
  logic          BUSY;
  logic          FULL;
  logic [LW-1:0] LEVEL;
  logic          OVERFLOW;

  int n_cmp = 0;
  int n_err = 0;

  pi_request_queue #(.DEPTH(DEPTH), .LW(LW)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET), .PI_WR_STROBE(PI_WR_STROBE), .PI_A(PI_A),
    .PI_DATA(PI_DATA), .CMD_VALID(CMD_VALID), .CMD_ADDR(CMD_ADDR), .CMD_FC(CMD_FC),
    .CMD_READ(CMD_READ), .CMD_SIZE(CMD_SIZE), .CMD_DATA(CMD_DATA), .CMD_TAKE(CMD_TAKE),
    .CMD_DONE(CMD_DONE), .BUSY(BUSY), .FULL(FULL), .LEVEL(LEVEL), .OVERFLOW(OVERFLOW)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic pi_wr(input logic [2:0] a, input logic [15:0] d);
    PI_A = a; PI_DATA = d; PI_WR_STROBE = 1'b1;
    tick();
    PI_WR_STROBE = 1'b0;
  endtask

  task automatic take();
    CMD_TAKE = 1'b1;
    tick();
    CMD_TAKE = 1'b0;
  endtask

  task automatic done();
    CMD_DONE = 1'b1;
    tick();
    CMD_DONE = 1'b0;
  endtask

  task automatic commit_take(input logic [15:0] d);
    PI_A = R_ADDR_HI; PI_DATA = d; PI_WR_STROBE = 1'b1; CMD_TAKE = 1'b1;
    tick();
    PI_WR_STROBE = 1'b0; CMD_TAKE = 1'b0;
  endtask

  task automatic commit_done(input logic [15:0] d);
    PI_A = R_ADDR_HI; PI_DATA = d; PI_WR_STROBE = 1'b1; CMD_DONE = 1'b1;
    tick();
    PI_WR_STROBE = 1'b0; CMD_DONE = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic stage();
    pi_wr(R_DATA_LO, 16'hBEEF);
    pi_wr(R_DATA_HI, 16'hDEAD);
    pi_wr(R_ADDR_LO, 16'h1234);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    RESET = 1'b0;
    chk("rst_valid", CMD_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_full", FULL, 0);
    chk("rst_ovf", OVERFLOW, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_addr", CMD_ADDR, 0);
    chk("rst_data", CMD_DATA, 0);

    // Single posted write
    stage();
    chk("stage_level", LEVEL, 0);
    pi_wr(R_ADDR_HI, 16'h0BE5);
    chk("pw_valid", CMD_VALID, 1);
    chk("pw_addr", CMD_ADDR, 24'hE51234);
    chk("pw_fc", CMD_FC, 1);
    chk("pw_size", CMD_SIZE, 3);
    chk("pw_read", CMD_READ, 0);
    chk("pw_data", CMD_DATA, 32'hDEADBEEF);
    chk("pw_level", LEVEL, 1);
    chk("pw_busy", BUSY, !POSTED);
    take();
    chk("pw_tk_valid", CMD_VALID, 0);
    chk("pw_tk_level", LEVEL, 0);
    chk("pw_tk_addr", CMD_ADDR, 24'hE51234);
    chk("pw_tk_busy", BUSY, !POSTED);
    done();
    chk("pw_dn_busy", BUSY, 0);
    chk("pw_dn_valid", CMD_VALID, 0);

    // Fill to DEPTH, fifth commit is dropped
    for (int k = 1; k <= 4; k++) pi_wr(R_ADDR_HI, 16'h0100 | 16'(k));
    chk("fill_level", LEVEL, 4);
    chk("fill_full", FULL, 1);
    chk("fill_busy", BUSY, 1);
    chk("fill_ovf0", OVERFLOW, 0);
    pi_wr(R_ADDR_HI, 16'h0105);
    chk("ovf_level", LEVEL, 4);
    chk("ovf_flag", OVERFLOW, 1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_pop_valid", CMD_VALID, 1);
      chk("ovf_pop_addr", CMD_ADDR, {8'(k), 16'h1234});
      take();
      chk("ovf_pop_level", LEVEL, 64'(4 - k));
      done();
    end
    chk("ovf_sticky", OVERFLOW, 1);
    chk("ovf_empty_valid", CMD_VALID, 0);

    // Commit + TAKE while full
    do_reset();
    stage();
    for (int k = 1; k <= 4; k++) pi_wr(R_ADDR_HI, 16'h0200 | 16'(k));
    chk("ct_pre_full", FULL, 1);
    commit_take(16'h0205);
    chk("ct_level", LEVEL, 4);
    chk("ct_full", FULL, 1);
    chk("ct_ovf", OVERFLOW, 0);
    chk("ct_valid", CMD_VALID, 0);
    chk("ct_out_addr", CMD_ADDR, 24'h011234);
    chk("ct_out_size", CMD_SIZE, 2);
    done();
    for (int k = 2; k <= 5; k++) begin
      chk("ct_pop_addr", CMD_ADDR, {8'(k), 16'h1234});
      take();
      done();
    end
    chk("ct_end_level", LEVEL, 0);

    // Read blocks BUSY until its DONE
    pi_wr(R_ADDR_HI, 16'h0301);
    pi_wr(R_ADDR_HI, 16'h0302);
    chk("rb_wr_busy", BUSY, !POSTED);
    pi_wr(R_ADDR_HI, 16'h0403);
    chk("rb_rd_busy", BUSY, 1);
    take(); chk("rb_tk1_busy", BUSY, 1);
    done(); chk("rb_dn1_busy", BUSY, 1);
    take(); done(); chk("rb_dn2_busy", BUSY, 1);
    chk("rb_head_read", CMD_READ, 1);
    chk("rb_head_addr", CMD_ADDR, 24'h031234);
    take(); chk("rb_tk3_busy", BUSY, 1);
    done(); chk("rb_dn3_busy", BUSY, 0);
    chk("rb_level", LEVEL, 0);

    // Read commit coincident with DONE of a read: counter nets to one
    pi_wr(R_ADDR_HI, 16'h0404);
    take();
    commit_done(16'h0405);
    chk("cd_busy", BUSY, 1);
    chk("cd_level", LEVEL, 1);
    take(); done();
    chk("cd_end_busy", BUSY, 0);

    // Stray handshakes and ignored registers
    done();
    chk("sd_level", LEVEL, 0);
    chk("sd_valid", CMD_VALID, 0);
    chk("sd_busy", BUSY, 0);
    take();
    chk("st_level", LEVEL, 0);
    chk("st_valid", CMD_VALID, 0);
    pi_wr(R_STATUS, 16'h0005);
    pi_wr(R_CONTROL, 16'hFFFF);
    pi_wr(R_VERSION, 16'h0003);
    chk("ign_level", LEVEL, 0);
    pi_wr(R_ADDR_HI, 16'h0107);
    chk("ign_valid", CMD_VALID, 1);
    chk("ign_addr", CMD_ADDR, 24'h071234);
    chk("ign_data", CMD_DATA, 32'hDEADBEEF);

    // Reset while ISSUED with OVERFLOW set
    for (int k = 8; k <= 11; k++) pi_wr(R_ADDR_HI, 16'h0100 | 16'(k));
    chk("ri_ovf_set", OVERFLOW, 1);
    take();
    chk("ri_issued", CMD_VALID, 0);
    do_reset();
    chk("ri_valid", CMD_VALID, 0);
    chk("ri_level", LEVEL, 0);
    chk("ri_ovf", OVERFLOW, 0);
    chk("ri_busy", BUSY, 0);
    chk("ri_full", FULL, 0);
    chk("ri_addr", CMD_ADDR, 0);
    tick();
    chk("ri_post_valid", CMD_VALID, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
